// File: rtl/trace_pkg.sv
// Shared types and constants for the trace readout controller.
package trace_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_EMIT  = 2'd2,
    ST_PARAM = 2'd3
  } state_e;

  // Request codes
  localparam logic [7:0] GET_TRACE = 8'h06;
  localparam logic [7:0] GET_PARAM = 8'h86;

  // Default geometry
  localparam int TRACE_W_DEF = 256;
  localparam int WORD_W_DEF  = 16;

  // Number of bits a GET_TRACE actually reads: the request is clipped at the end of the trace.
  function automatic logic [8:0] clip_len(input logic [8:0] idx,
                                          input logic [8:0] len,
                                          input logic [8:0] lim);
    logic [8:0] room;
    room = lim - idx;
    return (len < room) ? len : room;
  endfunction

endpackage

// File: rtl/trace_if.sv
// Request and output-word channels of the trace controller.
interface trace_if
  import trace_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic [7:0]        bRequest;
  logic [8:0]        wIndex;
  logic [8:0]        wLength;
  logic [WORD_W-1:0] word_data;
  logic              word_valid;
  logic              word_ready;
  logic              word_last;

  // Controller side
  modport slave (
    input  req_valid, bRequest, wIndex, wLength, word_ready,
    output req_ready, word_data, word_valid, word_last
  );

  // Host side
  modport master (
    output req_valid, bRequest, wIndex, wLength, word_ready,
    input  req_ready, word_data, word_valid, word_last
  );

endinterface

// File: rtl/trace_word_pack.sv
// Packs serial trace bits into a word, bit 0 first, with a bit counter.
// data_o shows the word including the bit being pushed this cycle, so the
// controller can capture a complete word on the same edge that samples its
// final bit. full_o flags that the current push completes the word.
module trace_word_pack
  import trace_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic              bit_i,
  output logic [WORD_W-1:0] data_o,
  output logic              full_o
);

  localparam int CNT_W = $clog2(WORD_W);

  logic [WORD_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Next packed value: clear wins over push
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    if (clear_i) begin
      data_d = {WORD_W{1'b0}};
      cnt_d  = {CNT_W{1'b0}};
    end else if (push_i) begin
      data_d[cnt_q] = bit_i;
      cnt_d         = cnt_q + CNT_W'(1);
    end else begin
      data_d = data_q;
      cnt_d  = cnt_q;
    end
  end

  // Pack register and bit counter
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= {WORD_W{1'b0}};
      cnt_q  <= {CNT_W{1'b0}};
    end else begin
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign data_o = data_d;
  assign full_o = push_i && (cnt_q == CNT_W'(WORD_W - 1));

endmodule

// File: rtl/trace_ctrl.sv
// Trace readout controller: serially samples a trace vector through an
// external bit mux (select -> q) and returns it as packed words, or returns
// the last index sampled by the previous trace read.
module trace_ctrl
  import trace_pkg::*;
#(
  parameter int TRACE_W = TRACE_W_DEF,
  parameter int WORD_W  = WORD_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  trace_if.slave     bus,
  output logic [8:0] select,
  input  logic       q,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam logic [8:0] TRACE_LIM = 9'(TRACE_W);

  state_e            state_q, state_d;
  logic [8:0]        select_q, select_d;
  logic [8:0]        last_select_q, last_select_d;
  logic [8:0]        rem_q, rem_d;
  logic [WORD_W-1:0] word_data_q, word_data_d;
  logic              word_valid_q, word_valid_d;
  logic              word_last_q, word_last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              req_ready_q;

  logic              accept_s;
  logic              hs_s;
  logic              pack_clear_s;
  logic              pack_push_s;
  logic [WORD_W-1:0] pack_data_s;
  logic              pack_full_s;

  assign accept_s = bus.req_valid && req_ready_q;
  assign hs_s     = word_valid_q && bus.word_ready;

  trace_word_pack #(
    .WORD_W (WORD_W)
  ) u_pack (
    .clk     (clk),
    .reset   (reset),
    .clear_i (pack_clear_s),
    .push_i  (pack_push_s),
    .bit_i   (q),
    .data_o  (pack_data_s),
    .full_o  (pack_full_s)
  );

  // Next-state and datapath decisions; select always equals the index being sampled in SCAN
  always_comb begin
    state_d       = state_q;
    select_d      = select_q;
    last_select_d = last_select_q;
    rem_d         = rem_q;
    word_data_d   = word_data_q;
    word_valid_d  = word_valid_q;
    word_last_d   = word_last_q;
    done_d        = 1'b0;
    err_d         = 1'b0;
    pack_clear_s  = 1'b0;
    pack_push_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (bus.bRequest == GET_TRACE) begin
            // An out-of-range start index is reported even for a zero length
            if (bus.wIndex >= TRACE_LIM) begin
              err_d = 1'b1;
            end else if (bus.wLength == 9'd0) begin
              done_d = 1'b1;
            end else begin
              state_d      = ST_SCAN;
              select_d     = bus.wIndex;
              rem_d        = clip_len(bus.wIndex, bus.wLength, TRACE_LIM);
              pack_clear_s = 1'b1;
            end
          end else if (bus.bRequest == GET_PARAM) begin
            state_d      = ST_PARAM;
            word_data_d  = WORD_W'(last_select_q);
            word_valid_d = 1'b1;
            word_last_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SCAN: begin
        pack_push_s   = 1'b1;
        rem_d         = rem_q - 9'd1;
        last_select_d = select_q;
        if ((rem_q == 9'd1) || pack_full_s) begin
          state_d      = ST_EMIT;
          word_data_d  = pack_data_s;
          word_valid_d = 1'b1;
          word_last_d  = (rem_q == 9'd1);
        end else begin
          select_d = select_q + 9'd1;
        end
      end
      ST_EMIT: begin
        if (hs_s) begin
          word_valid_d = 1'b0;
          word_last_d  = 1'b0;
          pack_clear_s = 1'b1;
          if (rem_q == 9'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d  = ST_SCAN;
            select_d = select_q + 9'd1;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_PARAM: begin
        if (hs_s) begin
          state_d      = ST_IDLE;
          word_valid_d = 1'b0;
          word_last_d  = 1'b0;
        end else begin
          state_d = ST_PARAM;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any request in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      select_q      <= 9'd0;
      last_select_q <= 9'd0;
      rem_q         <= 9'd0;
      word_data_q   <= {WORD_W{1'b0}};
      word_valid_q  <= 1'b0;
      word_last_q   <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      req_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      select_q      <= select_d;
      last_select_q <= last_select_d;
      rem_q         <= rem_d;
      word_data_q   <= word_data_d;
      word_valid_q  <= word_valid_d;
      word_last_q   <= word_last_d;
      done_q        <= done_d;
      err_q         <= err_d;
      req_ready_q   <= (state_d == ST_IDLE);
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.word_data  = word_data_q;
  assign bus.word_valid = word_valid_q;
  assign bus.word_last  = word_last_q;
  assign select         = select_q;
  assign busy           = (state_q != ST_IDLE);
  assign err            = err_q;
  // Completion of a word stream coincides with the final handshake; empty requests finish a cycle later
  assign done           = done_q | (hs_s && word_last_q);

endmodule
